// File: rtl/pe_demux_pkg.sv
// +--------------------------------------------------------------------+
// | pe_demux_pkg : shared types for the PE psum stream demultiplexer    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package pe_demux_pkg;

  typedef enum logic [1:0] {
    DEMUX_ADDR  = 2'd0,
    DEMUX_SEQ   = 2'd1,
    DEMUX_BCAST = 2'd2,
    DEMUX_DROP  = 2'd3
  } demux_mode_e;

endpackage

`default_nettype wire

// File: rtl/pe_demux_stream_if.sv
// +--------------------------------------------------------------------+
// | pe_demux_stream_if : input beat and per-channel output bundle       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface pe_demux_stream_if
  import pe_demux_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int DATA_DEPTH = 63,
  parameter int SEL_WIDTH  = $clog2(DATA_DEPTH)
);

  demux_mode_e                          mode;
  logic                                 in_valid;
  logic                                 in_ready;
  logic [DATA_WIDTH-1:0]                in_data;
  logic [SEL_WIDTH-1:0]                 in_sel;
  logic                                 seq_clr;
  logic [DATA_DEPTH-1:0]                out_valid;
  logic [DATA_DEPTH-1:0]                out_ready;
  logic [DATA_DEPTH*DATA_WIDTH-1:0]     out_data;
  logic [SEL_WIDTH-1:0]                 seq_ptr;
  logic                                 sel_err;
  logic                                 busy;

  modport master (
    output mode, in_valid, in_data, in_sel, seq_clr, out_ready,
    input  in_ready, out_valid, out_data, seq_ptr, sel_err, busy
  );

  modport slave (
    input  mode, in_valid, in_data, in_sel, seq_clr, out_ready,
    output in_ready, out_valid, out_data, seq_ptr, sel_err, busy
  );

endinterface

`default_nettype wire

// File: rtl/pe_demux_rr_ptr.sv
// +--------------------------------------------------------------------+
// | pe_demux_rr_ptr : wrap-at-DEPTH sequential channel pointer          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module pe_demux_rr_ptr #(
  parameter int DEPTH     = 63,
  parameter int PTR_WIDTH = $clog2(DEPTH)
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  input  wire logic                 clr,
  input  wire logic                 inc,
  output logic [PTR_WIDTH-1:0]      ptr
);

  localparam logic [PTR_WIDTH-1:0] c_last = PTR_WIDTH'(DEPTH - 1);

  logic [PTR_WIDTH-1:0] r_ptr;

  // Clear beats increment so a SEQ beat taken with seq_clr still lands on the old pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (clr) begin
      r_ptr <= '0;
    end else if (inc) begin
      r_ptr <= (r_ptr == c_last) ? '0 : r_ptr + 1'b1;
    end
  end

  assign ptr = r_ptr;

endmodule

`default_nettype wire

// File: rtl/pe_demux_stream.sv
// +--------------------------------------------------------------------+
// | pe_demux_stream : registered valid/ready 1-to-N psum demultiplexer  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module pe_demux_stream
  import pe_demux_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int DATA_DEPTH = 63,
  parameter int SEL_WIDTH  = $clog2(DATA_DEPTH)
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  pe_demux_stream_if.slave   bus
);

  localparam logic [SEL_WIDTH:0] c_depth = (SEL_WIDTH + 1)'(DATA_DEPTH);

  logic [DATA_DEPTH-1:0] r_pend;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_sel_err;

  logic [DATA_DEPTH-1:0] w_sel_hot;
  logic [DATA_DEPTH-1:0] w_seq_hot;
  logic [DATA_DEPTH-1:0] w_load_mask;
  logic [SEL_WIDTH-1:0]  w_seq_ptr;
  logic                  w_sel_ok;
  logic                  w_done;
  logic                  w_accept;
  logic                  w_seq_inc;

  // A new beat may enter only when every pending channel retires this cycle.
  assign w_done    = &(~r_pend | bus.out_ready);
  assign w_accept  = bus.in_valid & w_done;
  assign w_sel_ok  = {1'b0, bus.in_sel} < c_depth;
  assign w_seq_inc = w_accept & (bus.mode == DEMUX_SEQ);

  pe_demux_rr_ptr #(
    .DEPTH     (DATA_DEPTH),
    .PTR_WIDTH (SEL_WIDTH)
  ) u_rr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.seq_clr),
    .inc   (w_seq_inc),
    .ptr   (w_seq_ptr)
  );

  generate
    for (genvar gi = 0; gi < DATA_DEPTH; gi++) begin : g_chan
      assign w_sel_hot[gi] = (bus.in_sel == SEL_WIDTH'(gi));
      assign w_seq_hot[gi] = (w_seq_ptr == SEL_WIDTH'(gi));
      // Idle channels present zero rather than the last payload.
      assign bus.out_data[gi*DATA_WIDTH +: DATA_WIDTH] = r_pend[gi] ? r_data : '0;
    end
  endgenerate

  always_comb begin
    w_load_mask = '0;
    case (bus.mode)
      DEMUX_ADDR:  w_load_mask = w_sel_ok ? w_sel_hot : '0;
      DEMUX_SEQ:   w_load_mask = w_seq_hot;
      DEMUX_BCAST: w_load_mask = '1;
      default:     w_load_mask = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend    <= '0;
      r_data    <= '0;
      r_sel_err <= 1'b0;
    end else begin
      r_sel_err <= w_accept & (bus.mode == DEMUX_ADDR) & ~w_sel_ok;
      if (w_accept) begin
        r_pend <= w_load_mask;
        r_data <= bus.in_data;
      end else begin
        r_pend <= r_pend & ~bus.out_ready;
      end
    end
  end

  assign bus.in_ready  = w_done;
  assign bus.out_valid = r_pend;
  assign bus.seq_ptr   = w_seq_ptr;
  assign bus.sel_err   = r_sel_err;
  assign bus.busy      = |r_pend;

endmodule

`default_nettype wire
